// File: rtl/equiv_monitor.sv
// equiv_monitor: lockstep equivalence checker for two implementations.
// Each side passes through an optional register delay so that the two
// streams line up. After a warm-up period the aligned values are compared
// on every enabled cycle. The monitor records the first difference, keeps a
// sticky error flag and maintains a saturating mismatch count.
// Optional build macro: EQUIV_MONITOR_ASSERT_EN adds a clocked immediate
// assertion that fires on every mismatch event.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_WARMUP | ignore results until WARMUP enabled cycles have elapsed
// ST_ARMED  | comparing; no difference seen since reset or clear
// ST_FAILED | first difference captured; only pulse and count from here

module equiv_monitor #(
  parameter int WIDTH   = 91,
  parameter int DELAY_A = 0,
  parameter int DELAY_B = 0,
  parameter int WARMUP  = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  output logic             mismatch,
  output logic             error,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_cycle,
  output logic [WIDTH-1:0] first_diff,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } st_t;

  // The warm-up counter must be able to hold WARMUP itself.
  localparam int WW = $clog2(WARMUP + 2);

  logic [WIDTH-1:0] a_d, b_d;
  st_t              st_q, st_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcyc_q, fcyc_d;
  logic [WIDTH-1:0] fdiff_q, fdiff_d;
  logic             err_q, err_d;
  logic             mm_q, mm_d;
  logic             diff_ev;

  // Side A alignment: pass-through or a DELAY_A deep shift register.
  if (DELAY_A == 0) begin : g_a_pass
    assign a_d = y_a;
  end else begin : g_a_pipe
    logic [WIDTH-1:0] stg [DELAY_A];
    // Stages shift every clock, independent of en.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DELAY_A; i++) stg[i] <= '0;
      end else begin
        stg[0] <= y_a;
        for (int i = 1; i < DELAY_A; i++) stg[i] <= stg[i-1];
      end
    end
    assign a_d = stg[DELAY_A-1];
  end

  // Side B alignment: pass-through or a DELAY_B deep shift register.
  if (DELAY_B == 0) begin : g_b_pass
    assign b_d = y_b;
  end else begin : g_b_pipe
    logic [WIDTH-1:0] stg [DELAY_B];
    // Stages shift every clock, independent of en.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DELAY_B; i++) stg[i] <= '0;
      end else begin
        stg[0] <= y_b;
        for (int i = 1; i < DELAY_B; i++) stg[i] <= stg[i-1];
      end
    end
    assign b_d = stg[DELAY_B-1];
  end

  // State, counters and capture registers; reset discards all history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_WARMUP;
      warm_q  <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      fcyc_q  <= '0;
      fdiff_q <= '0;
      err_q   <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      warm_q  <= warm_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      fcyc_q  <= fcyc_d;
      fdiff_q <= fdiff_d;
      err_q   <= err_d;
      mm_q    <= mm_d;
    end
  end

  // Next-state logic: warm-up, compare, capture; clear overrides a same-edge event.
  always_comb begin
    st_d    = st_q;
    warm_d  = warm_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    fcyc_d  = fcyc_q;
    fdiff_d = fdiff_q;
    err_d   = err_q;
    mm_d    = 1'b0;
    diff_ev = en && (st_q != ST_WARMUP) && (a_d != b_d);

    // cyc is free-running on enabled cycles and survives clear.
    if (en && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;

    if (clear) begin
      st_d    = ST_ARMED;
      cnt_d   = '0;
      fcyc_d  = '0;
      fdiff_d = '0;
      err_d   = 1'b0;
    end else begin
      case (st_q)
        ST_WARMUP: begin
          if (WARMUP == 0) begin
            st_d = ST_ARMED;
          end else if (en) begin
            warm_d = warm_q + 1'b1;
            if (warm_q + 1'b1 == WW'(WARMUP)) st_d = ST_ARMED;
          end
        end
        ST_ARMED, ST_FAILED: begin
          if (diff_ev) begin
            mm_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (st_q == ST_ARMED) begin
              fcyc_d  = cyc_q;
              fdiff_d = a_d ^ b_d;
              err_d   = 1'b1;
              st_d    = ST_FAILED;
            end
          end
        end
        default: st_d = ST_WARMUP;
      endcase
    end
  end

`ifdef EQUIV_MONITOR_ASSERT_EN
  // Flag every compared cycle whose aligned values differ.
  always @(posedge clk) begin
    if (!rst && en && !clear && (st_q != ST_WARMUP))
      assert (a_d == b_d)
      else $error("equiv_monitor: mismatch at cycle %0d", cyc_q);
  end
`endif

  assign mismatch       = mm_q;
  assign error          = err_q;
  assign mismatch_count = cnt_q;
  assign first_cycle    = fcyc_q;
  assign first_diff     = fdiff_q;
  assign state          = st_q;

endmodule

// File: tb/tb_equiv_monitor.sv
// Directed bench for equiv_monitor: four instances cover the default
// configuration, side-A delays of 2 and 1, and a 3-bit counter width.
module tb_equiv_monitor;

  logic clk = 1'b0;
  logic rst, en, clear;

  logic [90:0] y_a0, y_b0;
  logic        mm0, err0;
  logic [15:0] cnt0, fc0;
  logic [90:0] fd0;
  logic [1:0]  st0;

  logic [7:0]  y_a8, y_b8;
  logic        mm2, err2, mm1, err1;
  logic [15:0] cnt2, fc2, cnt1, fc1;
  logic [7:0]  fd2, fd1;
  logic [1:0]  st2, st1;

  logic [7:0]  y_a3, y_b3;
  logic        mm3, err3;
  logic [2:0]  cnt3, fc3;
  logic [7:0]  fd3;
  logic [1:0]  st3;

  int n_err = 0;
  int n_chk = 0;
  logic seen_mm;
  logic [7:0] hist1, hist2;

  always #5 clk = ~clk;

  equiv_monitor u0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .y_a(y_a0), .y_b(y_b0),
    .mismatch(mm0), .error(err0), .mismatch_count(cnt0), .first_cycle(fc0),
    .first_diff(fd0), .state(st0));

  equiv_monitor #(.WIDTH(8), .DELAY_A(2)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .y_a(y_a8), .y_b(y_b8),
    .mismatch(mm2), .error(err2), .mismatch_count(cnt2), .first_cycle(fc2),
    .first_diff(fd2), .state(st2));

  equiv_monitor #(.WIDTH(8), .DELAY_A(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .y_a(y_a8), .y_b(y_b8),
    .mismatch(mm1), .error(err1), .mismatch_count(cnt1), .first_cycle(fc1),
    .first_diff(fd1), .state(st1));

  equiv_monitor #(.WIDTH(8), .CNT_W(3)) u_c3 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .y_a(y_a3), .y_b(y_b3),
    .mismatch(mm3), .error(err3), .mismatch_count(cnt3), .first_cycle(fc3),
    .first_diff(fd3), .state(st3));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  function automatic logic [90:0] rnd91();
    return 91'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0;
    y_a0 = '0; y_b0 = '0; y_a8 = '0; y_b8 = '0; y_a3 = '0; y_b3 = '0;
    #1;
    check("rst_state", st0, 2'd0);
    check("rst_error", err0, 1'b0);
    check("rst_mismatch", mm0, 1'b0);
    check("rst_count", cnt0, 16'd0);
    check("rst_first_cycle", fc0, 16'd0);
    check("rst_first_diff", fd0, 91'd0);
    #2 rst = 1'b0;

    // Scenario 1: identical random streams, no failure.
    en = 1'b1;
    seen_mm = 1'b0;
    for (int n = 0; n < 100; n++) begin
      y_a0 = rnd91();
      y_b0 = y_a0;
      tick();
      if (mm0) seen_mm = 1'b1;
      if (n == 2) check("s1_still_warmup", st0, 2'd0);
      if (n == 3) check("s1_armed_at_4", st0, 2'd1);
    end
    check("s1_error", err0, 1'b0);
    check("s1_count", cnt0, 16'd0);
    check("s1_no_pulse", seen_mm, 1'b0);
    check("s1_state", st0, 2'd1);

    // Scenario 2: single bit-0 difference at cycle 10.
    do_reset();
    for (int n = 0; n < 15; n++) begin
      y_a0 = rnd91();
      y_b0 = y_a0 ^ ((n == 10) ? 91'd1 : 91'd0);
      tick();
      if (n == 9) check("s2_no_pulse_before", mm0, 1'b0);
      if (n == 10) begin
        check("s2_pulse", mm0, 1'b1);
        check("s2_first_cycle", fc0, 16'd10);
        check("s2_first_diff", fd0, 91'd1);
        check("s2_error", err0, 1'b1);
        check("s2_state", st0, 2'd2);
      end
      if (n == 11) check("s2_pulse_one_cycle", mm0, 1'b0);
    end
    check("s2_count", cnt0, 16'd1);

    // Scenario 3: side A delayed by 2 against an externally delayed side B.
    do_reset();
    hist1 = '0; hist2 = '0;
    for (int n = 0; n < 20; n++) begin
      y_a8 = 8'(n + 1);
      y_b8 = hist2;
      tick();
      hist2 = hist1;
      hist1 = y_a8;
      if (n == 3) check("s3_d1_clean_in_warmup", err1, 1'b0);
      if (n == 4) begin
        check("s3_d1_error", err1, 1'b1);
        check("s3_d1_first_cycle", fc1, 16'd4);
        check("s3_d1_first_diff", fd1, 8'h07);
      end
    end
    check("s3_d2_error", err2, 1'b0);
    check("s3_d2_count", cnt2, 16'd0);
    check("s3_d2_state", st2, 2'd1);

    // Scenario 4: persistent difference saturates a 3-bit counter.
    do_reset();
    y_a3 = 8'h55; y_b3 = 8'h55;
    for (int n = 0; n < 4; n++) tick();
    y_b3 = 8'hAA;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (n == 0) begin
        check("s4_first_count", cnt3, 3'd1);
        check("s4_first_cycle", fc3, 3'd4);
      end
      if (n == 6) check("s4_count_reaches_7", cnt3, 3'd7);
    end
    check("s4_count_sat", cnt3, 3'd7);
    check("s4_first_cycle_held", fc3, 3'd4);
    check("s4_first_diff", fd3, 8'hFF);
    check("s4_pulse_persistent", mm3, 1'b1);
    y_b3 = 8'h55;

    // Scenario 5: clear wins over a coincident mismatch; en=0 freezes.
    do_reset();
    y_a0 = rnd91(); y_b0 = y_a0;
    for (int n = 0; n < 4; n++) tick();
    y_b0 = y_a0 ^ 91'h8;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("s5_clear_count", cnt0, 16'd0);
    check("s5_clear_error", err0, 1'b0);
    check("s5_clear_no_pulse", mm0, 1'b0);
    check("s5_clear_state", st0, 2'd1);
    y_b0 = y_a0;
    tick();
    en = 1'b0;
    y_b0 = y_a0 ^ 91'h4;
    tick();
    check("s5_en0_no_pulse", mm0, 1'b0);
    check("s5_en0_no_error", err0, 1'b0);
    check("s5_en0_state", st0, 2'd1);
    en = 1'b1;
    y_b0 = y_a0 ^ 91'h20;
    tick();
    check("s5_next_first_cycle", fc0, 16'd6);
    check("s5_next_first_diff", fd0, 91'h20);
    check("s5_next_error", err0, 1'b1);
    check("s5_next_count", cnt0, 16'd1);

    // Scenario 6: asynchronous reset out of FAILED, then fresh warm-up.
    #2 rst = 1'b1;
    #1;
    check("s6_async_state", st0, 2'd0);
    check("s6_async_error", err0, 1'b0);
    check("s6_async_count", cnt0, 16'd0);
    check("s6_async_first_cycle", fc0, 16'd0);
    check("s6_async_first_diff", fd0, 91'd0);
    #1 rst = 1'b0;
    seen_mm = 1'b0;
    y_b0 = y_a0 ^ 91'h1;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (mm0) seen_mm = 1'b1;
    end
    check("s6_warmup_no_pulse", seen_mm, 1'b0);
    check("s6_warmup_no_error", err0, 1'b0);
    check("s6_warmup_count", cnt0, 16'd0);
    check("s6_rearmed", st0, 2'd1);
    tick();
    check("s6_after_error", err0, 1'b1);
    check("s6_after_first_cycle", fc0, 16'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
